cache_mem_arbiter: RTL

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_pkg.sv | 38 +++
 rtl/arb_pick.sv | 36 +++
 rtl/cache_mem_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache-to-RAM arbiter.
// The ARB_ROUND_ROBIN_EN macro selects the arbitration policy. It is used in
// arb_pick.sv and cache_mem_arbiter.sv; this package is the same in both builds.
package cache_pkg;

    localparam int unsigned LINE_W   = 256;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned LINE_OFS = 5;

    // Bit positions inside the one-hot grant vector
    localparam int unsigned GNT_I = 0;
    localparam int unsigned GNT_D = 1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_I    = 2'b01,
        OWN_D    = 2'b10
    } owner_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10,
        DONE    = 2'b11
    } state_e;

    // Request held for RAM for the whole transaction
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } ram_req_t;

    // Clear the byte offset inside a cache line
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'((1 << LINE_OFS) - 1);
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Tie-break between I-cache and D-cache requests; one-hot grant output.
// Macro ARB_ROUND_ROBIN_EN: defined -> a tie goes to the side not served last;
// undefined -> the D-cache wins every tie and last_owner_i is ignored.
module arb_pick
    import cache_pkg::*;
(
    input  logic       i_req_i,
    input  logic       d_req_i,
    input  owner_e     last_owner_i,
    output logic [1:0] grant_o
);

    // Pick a single winner from the live requests
    always_comb begin
        grant_o = 2'b00;
        if (i_req_i && d_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_o[GNT_I] = (last_owner_i == OWN_D);
            grant_o[GNT_D] = (last_owner_i != OWN_D);
`else
            grant_o[GNT_D] = 1'b1;
`endif
        end else if (d_req_i) begin
            grant_o[GNT_D] = 1'b1;
        end else if (i_req_i) begin
            grant_o[GNT_I] = 1'b1;
        end
    end

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed-priority build has no use for the history input
    logic unused_last_owner;
    assign unused_last_owner = ^last_owner_i;
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache refills and D-cache refills/writebacks onto one RAM port.
// Macro ARB_ROUND_ROBIN_EN: defined -> last-owner register with alternating
// ties; undefined -> D-cache fixed priority and no last-owner register.
module cache_mem_arbiter
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [LINE_W-1:0] d_rdata,
    output logic              enable_cache_to_ram,
    output logic              write_cache_to_ram,
    output logic [ADDR_W-1:0] address_cache_to_ram,
    output logic [LINE_W-1:0] data_cache_to_ram_o,
    input  logic              response_ram_to_cache,
    input  logic [LINE_W-1:0] data_ram_to_cache_i,
    output logic [1:0]        owner
);

    state_e            state_q;
    owner_e            owner_q;
    ram_req_t          req_q;
    logic              en_q;
    logic              wr_q;
    logic              i_ack_q;
    logic              d_ack_q;
    logic [LINE_W-1:0] i_rdata_q;
    logic [LINE_W-1:0] d_rdata_q;
    logic [1:0]        grant;
    owner_e            last_owner;

`ifdef ARB_ROUND_ROBIN_EN
    owner_e last_owner_q;

    // Remember who finished last so the next tie goes the other way
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_q <= OWN_I;
        end else if (state_q == DONE) begin
            last_owner_q <= owner_q;
        end
    end

    assign last_owner = last_owner_q;
`else
    assign last_owner = OWN_I;
`endif

    arb_pick u_arb_pick (
        .i_req_i      (i_req),
        .d_req_i      (d_req),
        .last_owner_i (last_owner),
        .grant_o      (grant)
    );

    // Transaction FSM; every output comes straight from a register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_NONE;
            req_q     <= '0;
            en_q      <= 1'b0;
            wr_q      <= 1'b0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant[GNT_D]) begin
                        state_q     <= GRANT_D;
                        owner_q     <= OWN_D;
                        en_q        <= 1'b1;
                        wr_q        <= d_we;
                        req_q.addr  <= line_align(d_addr);
                        req_q.wdata <= d_wdata;
                    end else if (grant[GNT_I]) begin
                        state_q    <= GRANT_I;
                        owner_q    <= OWN_I;
                        en_q       <= 1'b1;
                        wr_q       <= 1'b0;
                        req_q.addr <= line_align(i_addr);
                    end
                end
                GRANT_I: begin
                    if (response_ram_to_cache) begin
                        state_q   <= DONE;
                        en_q      <= 1'b0;
                        wr_q      <= 1'b0;
                        i_rdata_q <= data_ram_to_cache_i;
                        i_ack_q   <= 1'b1;
                    end
                end
                GRANT_D: begin
                    if (response_ram_to_cache) begin
                        state_q   <= DONE;
                        en_q      <= 1'b0;
                        wr_q      <= 1'b0;
                        d_rdata_q <= data_ram_to_cache_i;
                        d_ack_q   <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    owner_q <= OWN_NONE;
                end
                default: begin
                    state_q <= IDLE;
                    owner_q <= OWN_NONE;
                    en_q    <= 1'b0;
                    wr_q    <= 1'b0;
                end
            endcase
        end
    end

    assign i_ack                = i_ack_q;
    assign d_ack                = d_ack_q;
    assign i_rdata              = i_rdata_q;
    assign d_rdata              = d_rdata_q;
    assign enable_cache_to_ram  = en_q;
    assign write_cache_to_ram   = wr_q;
    assign address_cache_to_ram = req_q.addr;
    assign data_cache_to_ram_o  = req_q.wdata;
    assign owner                = owner_q;

endmodule
